// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for stable PLL lock, holds all domains, then releases them one by one.
// Latency: registered outputs; pll_locked drop re-asserts every domain on the 3rd clk edge.
// Backpressure: none; sw_rst_req is a single-cycle request that is always accepted.
module reset_sequencer #(
   parameter int NUM_CH       = 4,
   parameter int LOCK_STABLE  = 32,
   parameter int HOLD_CYCLES  = 16,
   parameter int STAGE_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pll_locked,
   input  logic              sw_rst_req,
   output logic [NUM_CH-1:0] rst_out,
   output logic              ready,
   output logic [1:0]        state,
   output logic [7:0]        loss_count
);

   // One shared counter serves every timed state, so it is sized for the longest interval.
   localparam int MAX_P = (LOCK_STABLE > HOLD_CYCLES)
                        ? ((LOCK_STABLE > STAGE_CYCLES) ? LOCK_STABLE : STAGE_CYCLES)
                        : ((HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES);
   localparam int CW = (MAX_P > 1) ? $clog2(MAX_P) : 1;
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [CW-1:0] LS_LAST    = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);
   localparam logic [IW-1:0] CH_LAST    = IW'(NUM_CH - 1);

   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_HOLD      = 2'd1,
      S_RELEASE   = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_sync1;
   logic              r_sync2;
   logic              w_lock_s;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cnt_nxt;
   logic [IW-1:0]     r_idx;
   logic [IW-1:0]     w_idx_nxt;
   logic [NUM_CH-1:0] r_rst_out;
   logic [NUM_CH-1:0] w_rst_out_nxt;
   logic              r_ready;
   logic              w_ready_nxt;
   logic [7:0]        r_loss_cnt;
   logic [7:0]        w_loss_cnt_nxt;
   logic              w_lock_lost;
   logic              w_go_hold;

   assign w_lock_s = r_sync2;

   // Two-flop synchroniser bringing the asynchronous lock indication into clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   // Next-state and next-output decode; lock loss outranks the software request.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_idx_nxt      = r_idx;
      w_rst_out_nxt  = r_rst_out;
      w_ready_nxt    = r_ready;
      w_loss_cnt_nxt = r_loss_cnt;
      w_lock_lost    = 1'b0;
      w_go_hold      = 1'b0;

      case (r_state)
         S_WAIT_LOCK: begin
            w_rst_out_nxt = '1;
            w_ready_nxt   = 1'b0;
            w_idx_nxt     = '0;
            if (!w_lock_s) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == LS_LAST) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_HOLD: begin
            if (!w_lock_s) begin
               w_lock_lost = 1'b1;
            end else if (sw_rst_req) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == HOLD_LAST) begin
               w_state_nxt = S_RELEASE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_RELEASE: begin
            if (!w_lock_s) begin
               w_lock_lost = 1'b1;
            end else if (sw_rst_req) begin
               w_go_hold = 1'b1;
            end else if (r_cnt == STAGE_LAST) begin
               w_cnt_nxt                = '0;
               w_rst_out_nxt[r_idx]     = 1'b0;
               if (r_idx == CH_LAST) begin
                  w_state_nxt = S_RUN;
                  w_ready_nxt = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_RUN: begin
            if (!w_lock_s) begin
               w_lock_lost = 1'b1;
            end else if (sw_rst_req) begin
               w_go_hold = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_WAIT_LOCK;
         end
      endcase

      // Both restart paths re-assert every domain together.
      if (w_go_hold) begin
         w_state_nxt   = S_HOLD;
         w_cnt_nxt     = '0;
         w_idx_nxt     = '0;
         w_rst_out_nxt = '1;
         w_ready_nxt   = 1'b0;
      end

      if (w_lock_lost) begin
         w_state_nxt   = S_WAIT_LOCK;
         w_cnt_nxt     = '0;
         w_idx_nxt     = '0;
         w_rst_out_nxt = '1;
         w_ready_nxt   = 1'b0;
         if (r_loss_cnt != 8'hFF) begin
            w_loss_cnt_nxt = r_loss_cnt + 8'd1;
         end
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_WAIT_LOCK;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_rst_out  <= '1;
         r_ready    <= 1'b0;
         r_loss_cnt <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_rst_out  <= w_rst_out_nxt;
         r_ready    <= w_ready_nxt;
         r_loss_cnt <= w_loss_cnt_nxt;
      end
   end

   assign rst_out    = r_rst_out;
   assign ready      = r_ready;
   assign state      = r_state;
   assign loss_count = r_loss_cnt;

endmodule
